psum_writeback: RTL and testbench

//  Drains the corelet output FIFO into the output SRAM, acting as the reader of the ofifo (o_valid/rd) handshake.
//  On start, pops num_rows psum rows (col lanes each) and writes them to consecutive SRAM addresses from base_addr.

---
 rtl/psum_writeback.sv | 148 ++++++++++++++
 tb/tb_psum_writeback.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : psum_writeback
// Purpose  : Drains corelet ofifo rows into the output SRAM, optionally
//            accumulating lane-wise onto the stored word (read-modify-write).
// Revision : 1.0 - initial release
// ============================================================================
module psum_writeback #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 32,
  parameter int ADDR_BW = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BW-1:0]       base_addr,
  input  logic [ADDR_BW-1:0]       num_rows,
  input  logic                     acc_en,
  input  logic                     ofifo_valid,
  input  logic [PSUM_BW*COL-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [ADDR_BW-1:0]       sram_a,
  output logic [PSUM_BW*COL-1:0]   sram_d,
  input  logic [PSUM_BW*COL-1:0]   sram_q,
  output logic                     busy,
  output logic                     done
);

  localparam int DW = PSUM_BW * COL;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_BW-1:0] C_ONE = {{(ADDR_BW-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [ADDR_BW-1:0] base_q, base_d;
  logic [ADDR_BW-1:0] rows_q, rows_d;
  logic               acc_q, acc_d;
  logic [ADDR_BW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      data_q, data_d;
  logic [ADDR_BW-1:0] addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;

  logic               rd_c, cen_c, wen_c;
  logic [ADDR_BW-1:0] row_addr;
  logic [DW-1:0]      acc_sum;

  // Address wraps naturally at 2^ADDR_BW.
  assign row_addr = base_q + cnt_q;

  // Independent per-lane adders: no carry crosses a lane boundary.
  for (genvar l = 0; l < COL; l++) begin : g_lane
    assign acc_sum[l*PSUM_BW +: PSUM_BW] =
      data_q[l*PSUM_BW +: PSUM_BW] + sram_q[l*PSUM_BW +: PSUM_BW];
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rows_d  = rows_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_c    = 1'b0;
    cen_c   = 1'b1;
    wen_c   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          rows_d  = num_rows;
          acc_d   = acc_en;
          cnt_d   = '0;
          state_d = (num_rows == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (ofifo_valid) begin
          rd_c    = 1'b1;
          data_d  = ofifo_out;
          state_d = S_WRITE;
          if (acc_q) begin
            cen_c  = 1'b0;
            addr_d = row_addr;
          end
        end
      end
      S_WRITE: begin
        cen_c   = 1'b0;
        wen_c   = 1'b0;
        addr_d  = row_addr;
        wdata_d = acc_q ? acc_sum : data_q;
        if (cnt_q == rows_q - C_ONE) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + C_ONE;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and data buses hold their last driven value while idle.
  assign ofifo_rd = rd_c;
  assign sram_cen = cen_c;
  assign sram_wen = wen_c;
  assign sram_a   = addr_d;
  assign sram_d   = wdata_d;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      rows_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_writeback
// Purpose  : Directed, table-driven bench for psum_writeback with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_writeback;

  localparam int COL = 8;
  localparam int PBW = 32;
  localparam int ABW = 11;
  localparam int DW  = PBW * COL;
  localparam int OW  = 3 + ABW + DW + 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [ABW-1:0] base_addr;
  logic [ABW-1:0] num_rows;
  logic           acc_en;
  logic           ofifo_valid;
  logic [DW-1:0]  ofifo_out;
  logic           ofifo_rd;
  logic           sram_cen;
  logic           sram_wen;
  logic [ABW-1:0] sram_a;
  logic [DW-1:0]  sram_d;
  logic [DW-1:0]  sram_q;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  psum_writeback #(.COL(COL), .PSUM_BW(PBW), .ADDR_BW(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .busy(busy), .done(done)
  );

  // SRAM macro model: 1-cycle read latency, with a bench-side preload port.
  logic [DW-1:0]  mem [0:2047];
  logic           pre_we;
  logic [ABW-1:0] pre_a;
  logic [DW-1:0]  pre_d;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q <= mem[sram_a];
    end
  end

  typedef struct {
    logic r, s;
    logic [ABW-1:0] b, n;
    logic ac, fv;
    logic [31:0] fl;
    logic rd, cen, wen;
    logic [ABW-1:0] a;
    logic [31:0] dl;
    logic bz, dn;
  } vec_t;

  vec_t tv[$];
  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [DW-1:0] SENT     = {8{32'hDEADBEEF}};
  localparam logic [DW-1:0] ACC_INIT = {32'h7FFFFFFF, 32'd5, 32'd5, 32'd5,
                                        32'hFFFFFFFF, 32'd5, 32'd5, 32'd5};
  localparam logic [DW-1:0] ACC_ROW  = {32'd1, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                        32'd1, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
  localparam logic [DW-1:0] ACC_EXP  = {32'h80000000, 32'd2, 32'd2, 32'd2,
                                        32'd0, 32'd2, 32'd2, 32'd2};

  function automatic vec_t mk(input int r, s, b, n, ac, fv, fl,
                              rd, cen, wen, a, dl, bz, dn);
    vec_t x;
    x.r = r[0];   x.s = s[0];     x.b = b[ABW-1:0]; x.n = n[ABW-1:0];
    x.ac = ac[0]; x.fv = fv[0];   x.fl = fl;
    x.rd = rd[0]; x.cen = cen[0]; x.wen = wen[0];
    x.a = a[ABW-1:0]; x.dl = dl;  x.bz = bz[0];     x.dn = dn[0];
    return x;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {ofifo_rd, sram_cen, sram_wen, sram_a, sram_d, busy, done};
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive after the edge, leave the caller at the falling edge.
  task automatic cyc(input logic r, input logic s, input logic [ABW-1:0] b,
                     input logic [ABW-1:0] n, input logic ac, input logic fv,
                     input logic [DW-1:0] fo);
    @(posedge clk);
    #1;
    reset = r; start = s; base_addr = b; num_rows = n;
    acc_en = ac; ofifo_valid = fv; ofifo_out = fo;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; acc_en = 1'b0;
    ofifo_valid = 1'b0; ofifo_out = '0;
    pre_we = 1'b1; pre_a = 11'h055; pre_d = SENT;
    @(posedge clk); #1; pre_a = 11'h020; pre_d = ACC_INIT;
    @(posedge clk); #1; pre_a = 11'h042; pre_d = SENT;
    @(posedge clk); #1; pre_we = 1'b0;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,'h010,4,0,0,0, 0,1,1,0,0,0,0));
    // Overwrite, 4 rows from 0x010; start mid-drain must be ignored
    tv.push_back(mk(1,1,'h010,4,0,1,1,   0,1,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,1,1,       1,1,1,0,0,1,0));
    tv.push_back(mk(1,0,0,0,0,1,2,       0,0,0,'h010,1,1,0));
    tv.push_back(mk(1,1,'h100,7,1,1,2,   1,1,1,'h010,1,1,0));
    tv.push_back(mk(1,0,0,0,0,1,3,       0,0,0,'h011,2,1,0));
    tv.push_back(mk(1,0,0,0,0,1,3,       1,1,1,'h011,2,1,0));
    tv.push_back(mk(1,0,0,0,0,1,4,       0,0,0,'h012,3,1,0));
    tv.push_back(mk(1,0,0,0,0,1,4,       1,1,1,'h012,3,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,0,0,'h013,4,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,1,1,'h013,4,1,1));
    tv.push_back(mk(1,0,0,0,0,1,7,       0,1,1,'h013,4,0,0));
    // Address wrap 0x7FF -> 0x000
    tv.push_back(mk(1,1,'h7FF,2,0,1,'hA, 0,1,1,'h013,4,0,0));
    tv.push_back(mk(1,0,0,0,0,1,'hA,     1,1,1,'h013,4,1,0));
    tv.push_back(mk(1,0,0,0,0,1,'hB,     0,0,0,'h7FF,'hA,1,0));
    tv.push_back(mk(1,0,0,0,0,1,'hB,     1,1,1,'h7FF,'hA,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,0,0,'h000,'hB,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,1,1,0,'hB,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,1,1,0,'hB,0,0));
    // Zero rows: straight to DONE, no pop even with valid high
    tv.push_back(mk(1,1,'h055,0,0,1,'hC, 0,1,1,0,'hB,0,0));
    tv.push_back(mk(1,0,0,0,0,1,'hC,     0,1,1,0,'hB,1,1));
    tv.push_back(mk(1,0,0,0,0,1,'hC,     0,1,1,0,'hB,0,0));
    // Stalls before row 1 and between rows 1 and 2
    tv.push_back(mk(1,1,'h030,2,0,0,0,   0,1,1,0,'hB,0,0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0,'hB,1,0));
    tv.push_back(mk(1,0,0,0,0,1,'h11,    1,1,1,0,'hB,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,0,0,'h030,'h11,1,0));
    for (int i = 0; i < 5; i++) tv.push_back(mk(1,0,0,0,0,0,0, 0,1,1,'h030,'h11,1,0));
    tv.push_back(mk(1,0,0,0,0,1,'h22,    1,1,1,'h030,'h11,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,0,0,'h031,'h22,1,0));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,1,1,'h031,'h22,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,       0,1,1,'h031,'h22,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].r, tv[i].s, tv[i].b, tv[i].n, tv[i].ac, tv[i].fv, {8{tv[i].fl}});
      chk($sformatf("vec%0d", i), outs(),
          {tv[i].rd, tv[i].cen, tv[i].wen, tv[i].a, {8{tv[i].dl}}, tv[i].bz, tv[i].dn});
    end

    for (int k = 0; k < 4; k++)
      chk($sformatf("mem_ovw%0d", k), OW'(mem[11'h010 + 11'(k)]), OW'({8{k + 1}}));
    chk("mem_wrap_7ff", OW'(mem[11'h7FF]), OW'({8{32'hA}}));
    chk("mem_wrap_000", OW'(mem[11'h000]), OW'({8{32'hB}}));
    chk("mem_stall_0",  OW'(mem[11'h030]), OW'({8{32'h11}}));
    chk("mem_stall_1",  OW'(mem[11'h031]), OW'({8{32'h22}}));
    chk("mem_zero_rows", OW'(mem[11'h055]), OW'(SENT));

    // Accumulate: read 0x020 in FETCH, write lane-wise sum in WRITE
    cyc(1, 1, 11'h020, 11'd1, 1, 1, ACC_ROW);
    chk("acc_idle_busy", OW'(busy), OW'(1'b0));
    cyc(1, 0, '0, '0, 0, 1, ACC_ROW);
    chk("acc_read", OW'({ofifo_rd, sram_cen, sram_wen, sram_a}), OW'({3'b101, 11'h020}));
    cyc(1, 0, '0, '0, 0, 0, '0);
    chk("acc_write_ctl", OW'({sram_cen, sram_wen, sram_a}), OW'({2'b00, 11'h020}));
    chk("acc_write_data", OW'(sram_d), OW'(ACC_EXP));
    cyc(1, 0, '0, '0, 0, 0, '0);
    chk("acc_done", OW'({done, busy}), OW'(2'b11));
    chk("acc_mem", OW'(mem[11'h020]), OW'(ACC_EXP));

    // Abort with reset during WRITE of row 2, then clean restart
    cyc(1, 1, 11'h040, 11'd4, 0, 1, {8{32'h51}});
    cyc(1, 0, '0, '0, 0, 1, {8{32'h51}});
    cyc(1, 0, '0, '0, 0, 1, {8{32'h52}});
    cyc(1, 0, '0, '0, 0, 1, {8{32'h52}});
    cyc(0, 0, '0, '0, 0, 1, {8{32'h53}});
    chk("abort_in_row2", OW'({sram_wen, sram_a}), OW'({1'b0, 11'h041}));
    cyc(1, 0, '0, '0, 0, 1, {8{32'h53}});
    chk("abort_reset_state", outs(), OW'({3'b011, 11'h000, {DW{1'b0}}, 2'b00}));
    cyc(1, 0, '0, '0, 0, 1, {8{32'h53}});
    chk("abort_stay_idle", OW'({ofifo_rd, sram_cen, busy}), OW'(3'b010));
    cyc(1, 1, 11'h040, 11'd1, 0, 1, {8{32'h99}});
    cyc(1, 0, '0, '0, 0, 1, {8{32'h99}});
    chk("restart_fetch", OW'({ofifo_rd, sram_cen, busy}), OW'(3'b111));
    cyc(1, 0, '0, '0, 0, 0, '0);
    chk("restart_write", OW'({sram_cen, sram_wen, sram_a, sram_d}),
        OW'({2'b00, 11'h040, {8{32'h99}}}));
    cyc(1, 0, '0, '0, 0, 0, '0);
    chk("restart_done", OW'(done), OW'(1'b1));
    chk("restart_mem", OW'(mem[11'h040]), OW'({8{32'h99}}));
    chk("abort_no_row3", OW'(mem[11'h042]), OW'(SENT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
